alu_seq_acc: RTL and testbench

Parametrised, multi-cycle successor to the team's 4-bit combinational ALU. It adds a registered accumulator and flag register, carry-chained add/subtract, multi-bit shifts executed one bit per clock, and valid/ready handshakes on both input and output. It sits between the switch/bidirectional input decode and the display/flag output logic of a top-level tile, and can also be chained inside larger datapaths.

---
 rtl/alu_seq_acc.sv | 166 ++++++++++++++++
 tb/tb_alu_seq_acc.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/alu_seq_acc.sv
// alu_seq_acc: multi-cycle ALU with a registered accumulator and flag register.
//
// Arithmetic and logic ops complete in one cycle. Shifts by k>0 walk one bit
// per clock through a working register and complete after k cycles. A
// valid/ready handshake sits on both the request and the result side.
//
// Ports:
//   clk       system clock, rising edge
//   rst_n     asynchronous active-low reset
//   in_valid  operation request valid
//   in_ready  an operation can be accepted this cycle
//   op        opcode (ADD/SUB/ADC/SBB/AND/OR/XOR/SLL/SRL/SRA/ROL/PASS)
//   a, b      operands; shifts take the amount from b[SHW-1:0]
//   use_acc   take operand A from the result register instead of a
//   out_valid result and flags are valid
//   out_ready consumer accepts the result
//   result    registered result, also the accumulator
//   flags     registered {Z,N,C,V}
module alu_seq_acc #(
  parameter int WIDTH = 8,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             use_acc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flags
);

  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [3:0]       flags_q, flags_d;
  logic [WIDTH-1:0] wreg_q, wreg_d;
  logic [SHW-1:0]   cnt_q, cnt_d;
  logic [1:0]       sop_q, sop_d;   // captured shift kind: 00 SLL, 01 SRL, 10 SRA, 11 ROL

  // ---------------- single-cycle datapath ----------------
  logic [WIDTH-1:0] opa, bx, alu_res;
  logic [WIDTH:0]   sum;
  logic             cin, alu_c, alu_v, c_into_msb;
  logic             is_shift;
  logic [SHW-1:0]   k;

  assign opa      = use_acc ? result_q : a;
  assign is_shift = (op[3:2] == 2'b10);
  assign k        = b[SHW-1:0];

  always_comb begin
    bx  = b;
    cin = 1'b0;
    case (op)
      4'b0001: begin bx = ~b; cin = 1'b1;       end
      4'b0010: begin bx = b;  cin = flags_q[1]; end
      4'b0011: begin bx = ~b; cin = flags_q[1]; end
      default: begin bx = b;  cin = 1'b0;       end
    endcase
  end

  assign sum = {1'b0, opa} + {1'b0, bx} + {{WIDTH{1'b0}}, cin};
  // Carry into the MSB recovered from the MSB sum bit and its two inputs.
  assign c_into_msb = opa[WIDTH-1] ^ bx[WIDTH-1] ^ sum[WIDTH-1];

  always_comb begin
    alu_res = opa;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (op)
      4'b0000, 4'b0001, 4'b0010, 4'b0011: begin
        alu_res = sum[WIDTH-1:0];
        alu_c   = sum[WIDTH];
        alu_v   = c_into_msb ^ sum[WIDTH];
      end
      4'b0100: alu_res = opa & b;
      4'b0101: alu_res = opa | b;
      4'b0110: alu_res = opa ^ b;
      default: alu_res = opa;  // PASS, unknown codes, and shifts by 0
    endcase
  end

  // ---------------- one-bit shift step ----------------
  logic [WIDTH-1:0] step_val;
  logic             step_out;

  always_comb begin
    step_val = wreg_q;
    step_out = 1'b0;
    case (sop_q)
      2'b00: begin step_val = {wreg_q[WIDTH-2:0], 1'b0};          step_out = wreg_q[WIDTH-1]; end
      2'b01: begin step_val = {1'b0, wreg_q[WIDTH-1:1]};          step_out = wreg_q[0];       end
      2'b10: begin step_val = {wreg_q[WIDTH-1], wreg_q[WIDTH-1:1]}; step_out = wreg_q[0];     end
      default: begin step_val = {wreg_q[WIDTH-2:0], wreg_q[WIDTH-1]}; step_out = wreg_q[WIDTH-1]; end
    endcase
  end

  // ---------------- control ----------------
  assign in_ready  = (state_q == IDLE) | ((state_q == DONE) & out_ready);
  assign out_valid = (state_q == DONE);
  assign result    = result_q;
  assign flags     = flags_q;

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    flags_d  = flags_q;
    wreg_d   = wreg_q;
    cnt_d    = cnt_q;
    sop_d    = sop_q;
    case (state_q)
      SHIFT: begin
        cnt_d = cnt_q - SHW'(1);
        if (cnt_q == SHW'(1)) begin
          // Last step: commit straight from the step logic.
          result_d = step_val;
          flags_d  = {(step_val == '0), step_val[WIDTH-1], step_out, 1'b0};
          state_d  = DONE;
        end else begin
          wreg_d = step_val;
        end
      end
      default: begin  // IDLE or DONE
        if (in_valid && in_ready) begin
          if (is_shift && (k != '0)) begin
            wreg_d  = opa;
            cnt_d   = k;
            sop_d   = op[1:0];
            state_d = SHIFT;
          end else begin
            result_d = alu_res;
            flags_d  = {(alu_res == '0), alu_res[WIDTH-1], alu_c, alu_v};
            state_d  = DONE;
          end
        end else if (state_q == DONE && out_ready) begin
          state_d = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      result_q <= '0;
      flags_q  <= '0;
      wreg_q   <= '0;
      cnt_q    <= '0;
      sop_q    <= '0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      flags_q  <= flags_d;
      wreg_q   <= wreg_d;
      cnt_q    <= cnt_d;
      sop_q    <= sop_d;
    end
  end

endmodule

// File: tb/tb_alu_seq_acc.sv
// Directed testbench for alu_seq_acc (WIDTH=8).
module tb_alu_seq_acc;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [3:0]       op = 4'h0;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic             use_acc = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [WIDTH-1:0] result;
  logic [3:0]       flags;

  int checks = 0;
  int failures = 0;

  alu_seq_acc #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .a(a), .b(b), .use_acc(use_acc), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .flags(flags)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one request for exactly one edge (caller guarantees in_ready=1).
  task automatic issue(input logic [3:0] o, input logic [7:0] va, input logic [7:0] vb, input logic ua);
    op = o; a = va; b = vb; use_acc = ua; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    a = 8'hEE; b = 8'hEE; op = 4'h6; use_acc = 1'b0;  // later changes must not matter
  endtask

  task automatic check_res(input string tag, input logic [7:0] r, input logic [3:0] f);
    chk({tag, ".valid"}, {31'd0, out_valid}, 32'd1);
    chk({tag, ".result"}, {24'd0, result}, {24'd0, r});
    chk({tag, ".flags"}, {28'd0, flags}, {28'd0, f});
    $display("op %s: result=%02h flags=%04b", tag, result, flags);
  endtask

  initial begin
    // 1. Reset held across edges, then mid-cycle assertion after activity.
    tick(); tick();
    chk("rst.result", {24'd0, result}, 32'h00);
    chk("rst.flags", {28'd0, flags}, 32'h0);
    chk("rst.valid", {31'd0, out_valid}, 32'd0);
    #3 rst_n = 1'b1;
    #1 chk("rst.in_ready", {31'd0, in_ready}, 32'd1);
    tick();
    issue(4'b0000, 8'h7F, 8'h01, 1'b0);
    check_res("pre_rst_add", 8'h80, 4'b0101);
    #3 rst_n = 1'b0;
    #1;
    chk("rst_mid.result", {24'd0, result}, 32'h00);
    chk("rst_mid.flags", {28'd0, flags}, 32'h0);
    chk("rst_mid.valid", {31'd0, out_valid}, 32'd0);
    #2 rst_n = 1'b1;
    #1 chk("rst_mid.in_ready", {31'd0, in_ready}, 32'd1);
    tick();

    // 2. Basic arithmetic.
    issue(4'b0000, 8'h7F, 8'h01, 1'b0);
    check_res("add_7f_01", 8'h80, 4'b0101);
    tick();
    issue(4'b0001, 8'h05, 8'h05, 1'b0);
    check_res("sub_05_05", 8'h00, 4'b1010);
    tick();

    // 3. Carry chain (use_acc, and in DONE so these are back-to-back handoffs).
    issue(4'b0000, 8'hFF, 8'h01, 1'b0);
    check_res("add_ff_01", 8'h00, 4'b1010);
    issue(4'b0010, 8'h55, 8'h00, 1'b1);
    check_res("adc_acc_00", 8'h01, 4'b0000);
    issue(4'b0011, 8'h55, 8'h01, 1'b1);
    check_res("sbb_acc_01", 8'hFF, 4'b0100);
    tick();

    // Logic ops and an unassigned opcode (acts as PASS).
    issue(4'b0100, 8'hF0, 8'h3C, 1'b0);
    check_res("and", 8'h30, 4'b0000);
    issue(4'b0110, 8'hAA, 8'hAA, 1'b0);
    check_res("xor", 8'h00, 4'b1000);
    issue(4'b0101, 8'h81, 8'h06, 1'b0);
    check_res("or", 8'h87, 4'b0100);
    issue(4'b0111, 8'h80, 8'h12, 1'b0);
    check_res("op7_pass", 8'h80, 4'b0100);
    tick();

    // 4. Shifts.
    issue(4'b1010, 8'h90, 8'h03, 1'b0);
    for (int i = 0; i < 3; i++) begin
      chk("sra.busy_ready", {31'd0, in_ready}, 32'd0);
      chk("sra.busy_valid", {31'd0, out_valid}, 32'd0);
      chk("sra.hold_result", {24'd0, result}, 32'h80);
      if (i < 2) tick();
      else tick();
    end
    check_res("sra_90_3", 8'hF2, 4'b0100);
    tick();
    issue(4'b1000, 8'h81, 8'h01, 1'b0);
    chk("sll.busy_valid", {31'd0, out_valid}, 32'd0);
    tick();
    check_res("sll_81_1", 8'h02, 4'b0010);
    tick();
    issue(4'b1011, 8'h81, 8'h01, 1'b0);
    tick();
    check_res("rol_81_1", 8'h03, 4'b0010);
    tick();
    issue(4'b1001, 8'hA5, 8'h00, 1'b0);
    check_res("srl_a5_0", 8'hA5, 4'b0100);
    tick();

    // 5. Backpressure then simultaneous handoff.
    out_ready = 1'b0;
    issue(4'b0000, 8'h10, 8'h20, 1'b0);
    check_res("bp_add", 8'h30, 4'b0000);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp.valid", {31'd0, out_valid}, 32'd1);
      chk("bp.result", {24'd0, result}, 32'h30);
      chk("bp.in_ready", {31'd0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    #1 chk("bp.handoff_ready", {31'd0, in_ready}, 32'd1);
    issue(4'b0000, 8'h00, 8'h01, 1'b1);
    check_res("handoff_acc", 8'h31, 4'b0000);
    tick();
    chk("idle.valid", {31'd0, out_valid}, 32'd0);

    // 6. Reset mid-shift.
    issue(4'b1000, 8'h01, 8'h07, 1'b0);
    tick(); tick();
    #3 rst_n = 1'b0;
    #1;
    chk("rst_shift.valid", {31'd0, out_valid}, 32'd0);
    chk("rst_shift.result", {24'd0, result}, 32'h00);
    #2 rst_n = 1'b1;
    tick();
    chk("rst_shift.in_ready", {31'd0, in_ready}, 32'd1);
    issue(4'b0000, 8'h02, 8'h03, 1'b0);
    check_res("post_rst_add", 8'h05, 4'b0000);
    tick();
    chk("post_rst.idle_valid", {31'd0, out_valid}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
